// File: rtl/vga_sync_generator_pkg.sv
// Shared 640x480@60 Hz timing defaults and coordinate width for the VGA pipeline.
// The colour stage and tile addresser import the same constants.
package vga_sync_generator_pkg;

   localparam int COORD_W = 10;

   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;

   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   function automatic int axis_total(input int display, input int front,
                                     input int sync, input int back);
      return display + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running counter with wrap strobe and combinational
// visible / active-low sync decode of the current count.
module vga_axis_counter
   import vga_sync_generator_pkg::*;
#(
   parameter int DISPLAY = H_DISPLAY_DEF,
   parameter int FRONT   = H_FRONT_DEF,
   parameter int SYNC    = H_SYNC_DEF,
   parameter int BACK    = H_BACK_DEF
) (
   input  logic               clock_25,
   input  logic               reset_n,
   input  logic               enable,
   output logic [COORD_W-1:0] count,
   output logic               wrap,
   output logic               visible,
   output logic               sync_n
);

   localparam int TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);

   localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
   localparam logic [COORD_W-1:0] VIS_END    = COORD_W'(DISPLAY);
   localparam logic [COORD_W-1:0] SYNC_START = COORD_W'(DISPLAY + FRONT);
   localparam logic [COORD_W-1:0] SYNC_END   = COORD_W'(DISPLAY + FRONT + SYNC);

   logic [COORD_W-1:0] count_reg;
   logic [COORD_W-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (enable) begin
         if (count_reg == LAST)
            count_next = '0;
         else
            count_next = count_reg + 1'b1;
      end
   end

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n)
         count_reg <= '0;
      else
         count_reg <= count_next;
   end

   // Wrap is qualified by enable so the vertical axis only sees it on the last pixel of a line.
   assign wrap    = enable && (count_reg == LAST);
   assign visible = (count_reg < VIS_END);
   assign sync_n  = !((count_reg >= SYNC_START) && (count_reg < SYNC_END));
   assign count   = count_reg;

endmodule

// File: rtl/vga_sync_generator.sv
// 640x480@60 Hz raster timing generator: registered pixel coordinates and strobes,
// with hsync/vsync delayed by SYNC_DELAY extra flops to match the colour register.
module vga_sync_generator
   import vga_sync_generator_pkg::*;
#(
   parameter int H_DISPLAY  = H_DISPLAY_DEF,
   parameter int H_FRONT    = H_FRONT_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BACK     = H_BACK_DEF,
   parameter int V_DISPLAY  = V_DISPLAY_DEF,
   parameter int V_FRONT    = V_FRONT_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BACK     = V_BACK_DEF,
   parameter int SYNC_DELAY = 1
) (
   input  logic               clock_25,
   input  logic               reset_n,
   output logic               hsync,
   output logic               vsync,
   output logic               display_area,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               frame_end
);

   localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

   generate
      if (SYNC_DELAY < 0 || SYNC_DELAY > 3 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
         $error("vga_sync_generator: illegal SYNC_DELAY or raster totals exceed 10-bit counters");
      end
   endgenerate

   logic [COORD_W-1:0] h_count;
   logic [COORD_W-1:0] v_count;
   logic               h_wrap;
   logic               v_wrap;
   logic               h_visible;
   logic               v_visible;
   logic               h_sync_n;
   logic               v_sync_n;

   vga_axis_counter #(
      .DISPLAY (H_DISPLAY),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK)
   ) u_h_axis (
      .clock_25 (clock_25),
      .reset_n  (reset_n),
      .enable   (1'b1),
      .count    (h_count),
      .wrap     (h_wrap),
      .visible  (h_visible),
      .sync_n   (h_sync_n)
   );

   vga_axis_counter #(
      .DISPLAY (V_DISPLAY),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK)
   ) u_v_axis (
      .clock_25 (clock_25),
      .reset_n  (reset_n),
      .enable   (h_wrap),
      .count    (v_count),
      .wrap     (v_wrap),
      .visible  (v_visible),
      .sync_n   (v_sync_n)
   );

   logic               display_area_reg;
   logic [COORD_W-1:0] pixel_x_reg;
   logic [COORD_W-1:0] pixel_y_reg;
   logic               frame_end_reg;

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         display_area_reg <= 1'b0;
         pixel_x_reg      <= '0;
         pixel_y_reg      <= '0;
         frame_end_reg    <= 1'b0;
      end else begin
         display_area_reg <= h_visible && v_visible;
         pixel_x_reg      <= h_count;
         pixel_y_reg      <= v_count;
         frame_end_reg    <= v_wrap;
      end
   end

   // Element 0 is the stage-0 sync register; each further element is one delay flop.
   logic [SYNC_DELAY:0] hsync_pipe_reg;
   logic [SYNC_DELAY:0] vsync_pipe_reg;

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         hsync_pipe_reg[0] <= 1'b1;
         vsync_pipe_reg[0] <= 1'b1;
      end else begin
         hsync_pipe_reg[0] <= h_sync_n;
         vsync_pipe_reg[0] <= v_sync_n;
      end
   end

   generate
      for (genvar gi = 1; gi <= SYNC_DELAY; gi++) begin : g_sync_delay
         always_ff @(posedge clock_25 or negedge reset_n) begin
            if (!reset_n) begin
               hsync_pipe_reg[gi] <= 1'b1;
               vsync_pipe_reg[gi] <= 1'b1;
            end else begin
               hsync_pipe_reg[gi] <= hsync_pipe_reg[gi-1];
               vsync_pipe_reg[gi] <= vsync_pipe_reg[gi-1];
            end
         end
      end
   endgenerate

   assign hsync        = hsync_pipe_reg[SYNC_DELAY];
   assign vsync        = vsync_pipe_reg[SYNC_DELAY];
   assign display_area = display_area_reg;
   assign pixel_x      = pixel_x_reg;
   assign pixel_y      = pixel_y_reg;
   assign frame_end    = frame_end_reg;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Directed bench: full-size raster (SYNC_DELAY=1) for line timing, plus two small
// rasters (SYNC_DELAY=0 and 3) for frame, sync-shift and mid-frame reset behaviour.
module tb_vga_sync_generator;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic       hs_d, vs_d, da_d, fe_d;
   logic [9:0] px_d, py_d;
   logic       hs0, vs0, da0, fe0;
   logic [9:0] px0, py0;
   logic       hs3, vs3, da3, fe3;
   logic [9:0] px3, py3;

   vga_sync_generator dut (
      .clock_25(clk), .reset_n(reset_n), .hsync(hs_d), .vsync(vs_d),
      .display_area(da_d), .pixel_x(px_d), .pixel_y(py_d), .frame_end(fe_d)
   );

   // Small raster: 16 clocks per line (sync h=10..12), 8 lines per frame (sync v=5..6).
   vga_sync_generator #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(0)
   ) dut_s0 (
      .clock_25(clk), .reset_n(reset_n), .hsync(hs0), .vsync(vs0),
      .display_area(da0), .pixel_x(px0), .pixel_y(py0), .frame_end(fe0)
   );

   vga_sync_generator #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(3)
   ) dut_s3 (
      .clock_25(clk), .reset_n(reset_n), .hsync(hs3), .vsync(vs3),
      .display_area(da3), .pixel_x(px3), .pixel_y(py3), .frame_end(fe3)
   );

   int tests = 0;
   int fails = 0;
   int k     = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s (k=%0d): got %0d, expected %0d", name, k, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic run_to(input int target);
      while (k < target) tick();
   endtask

   typedef struct {
      int   k;
      logic da;
      int   px;
      int   py;
      logic hs;
      logic vs;
      logic fe;
   } dvec_t;

   typedef struct {
      int   k;
      logic da;
      int   px;
      int   py;
      logic fe;
      logic hs0;
      logic vs0;
      logic hs3;
      logic vs3;
   } svec_t;

   dvec_t dtab[9];
   svec_t stab[16];

   initial begin
      int low_cnt, first_low, da_cnt;
      int fe_cnt, last_fe, fe_bad, vs0_low, vs3_low, da_s0, da_diff, range_bad, coinc_bad;
      int hs0_fall, hs3_fall, vs0_fall, vs3_fall;
      logic p_hs0, p_hs3, p_vs0, p_vs3;

      // Full-size raster, SYNC_DELAY=1: stage-0 outputs describe count k-1, sync describes k-2.
      dtab[0] = '{1,   1'b1, 0,   0, 1'b1, 1'b1, 1'b0};
      dtab[1] = '{640, 1'b1, 639, 0, 1'b1, 1'b1, 1'b0};
      dtab[2] = '{641, 1'b0, 640, 0, 1'b1, 1'b1, 1'b0};
      dtab[3] = '{657, 1'b0, 656, 0, 1'b1, 1'b1, 1'b0};
      dtab[4] = '{658, 1'b0, 657, 0, 1'b0, 1'b1, 1'b0};
      dtab[5] = '{753, 1'b0, 752, 0, 1'b0, 1'b1, 1'b0};
      dtab[6] = '{754, 1'b0, 753, 0, 1'b1, 1'b1, 1'b0};
      dtab[7] = '{800, 1'b0, 799, 0, 1'b1, 1'b1, 1'b0};
      dtab[8] = '{801, 1'b1, 0,   1, 1'b1, 1'b1, 1'b0};

      // Small rasters: stage-0 describes n=k-1; SYNC_DELAY=3 sync describes k-4.
      stab[0]  = '{1,   1'b1, 0,  0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      stab[1]  = '{8,   1'b1, 7,  0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      stab[2]  = '{9,   1'b0, 8,  0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      stab[3]  = '{11,  1'b0, 10, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      stab[4]  = '{12,  1'b0, 11, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      stab[5]  = '{13,  1'b0, 12, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      stab[6]  = '{14,  1'b0, 13, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      stab[7]  = '{16,  1'b0, 15, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      stab[8]  = '{17,  1'b1, 0,  1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      stab[9]  = '{65,  1'b0, 0,  4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      stab[10] = '{81,  1'b0, 0,  5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      stab[11] = '{84,  1'b0, 3,  5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      stab[12] = '{113, 1'b0, 0,  7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      stab[13] = '{116, 1'b0, 3,  7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      stab[14] = '{128, 1'b0, 15, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      stab[15] = '{129, 1'b1, 0,  0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

      // Reset held 5 clocks.
      reset_n = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_hsync", hs_d, 1);
      chk("rst_vsync", vs_d, 1);
      chk("rst_display_area", da_d, 0);
      chk("rst_pixel_x", px_d, 0);
      chk("rst_pixel_y", py_d, 0);
      chk("rst_frame_end", fe_d, 0);
      chk("rst_hsync_d3", hs3, 1);
      chk("rst_vsync_d3", vs3, 1);
      $display("[TB] reset phase checked");

      @(negedge clk);
      reset_n = 1'b1;
      k = 0;

      foreach (dtab[i]) begin
         run_to(dtab[i].k);
         $display("[TB] full raster k=%0d x=%0d y=%0d da=%0b hs=%0b vs=%0b fe=%0b",
                  k, px_d, py_d, da_d, hs_d, vs_d, fe_d);
         chk("full_display_area", da_d, dtab[i].da);
         chk("full_pixel_x", px_d, dtab[i].px);
         chk("full_pixel_y", py_d, dtab[i].py);
         chk("full_hsync", hs_d, dtab[i].hs);
         chk("full_vsync", vs_d, dtab[i].vs);
         chk("full_frame_end", fe_d, dtab[i].fe);
      end

      // Second line, k=801..1600: hsync width/position and visible count.
      low_cnt = 0; first_low = -1; da_cnt = 0;
      for (int i = 0; i < 800; i++) begin
         if (!hs_d) begin
            low_cnt++;
            if (first_low < 0) first_low = k;
         end
         if (da_d) da_cnt++;
         if (i < 799) tick();
      end
      $display("[TB] line 2: hsync low %0d clocks from k=%0d, display %0d clocks",
               low_cnt, first_low, da_cnt);
      chk("line_hsync_low_width", low_cnt, 96);
      chk("line_hsync_start", first_low, 801 + 657);
      chk("line_display_clocks", da_cnt, 640);
      chk("line_end_pixel_x", px_d, 799);
      chk("line_end_pixel_y", py_d, 1);

      // Fresh reset for the small rasters, dropped between clock edges.
      @(posedge clk);
      #2 reset_n = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst2_hsync_d0", hs0, 1);
      chk("rst2_vsync_d3", vs3, 1);
      @(negedge clk);
      reset_n = 1'b1;
      k = 0;

      foreach (stab[i]) begin
         run_to(stab[i].k);
         $display("[TB] small raster k=%0d x=%0d y=%0d da=%0b fe=%0b hs0=%0b vs0=%0b hs3=%0b vs3=%0b",
                  k, px0, py0, da0, fe0, hs0, vs0, hs3, vs3);
         chk("small_display_area", da0, stab[i].da);
         chk("small_pixel_x", px0, stab[i].px);
         chk("small_pixel_y", py0, stab[i].py);
         chk("small_frame_end", fe0, stab[i].fe);
         chk("small_hsync_d0", hs0, stab[i].hs0);
         chk("small_vsync_d0", vs0, stab[i].vs0);
         chk("small_hsync_d3", hs3, stab[i].hs3);
         chk("small_vsync_d3", vs3, stab[i].vs3);
         chk("small_pixel_x_d3", px3, stab[i].px);
      end

      // Three whole frames, k=130..513.
      fe_cnt = 0; last_fe = -1; fe_bad = 0; vs0_low = 0; vs3_low = 0; da_s0 = 0;
      da_diff = 0; range_bad = 0; coinc_bad = 0;
      hs0_fall = -1; hs3_fall = -1; vs0_fall = -1; vs3_fall = -1;
      p_hs0 = hs0; p_hs3 = hs3; p_vs0 = vs0; p_vs3 = vs3;
      for (int i = 0; i < 384; i++) begin
         tick();
         if (fe0) begin
            fe_cnt++;
            if (last_fe >= 0 && k - last_fe != 128) fe_bad++;
            if (px0 != 10'd15 || py0 != 10'd7) coinc_bad++;
            last_fe = k;
         end
         if (!vs0) vs0_low++;
         if (!vs3) vs3_low++;
         if (da0) da_s0++;
         if (da0 != da3 || px0 != px3 || fe0 != fe3) da_diff++;
         if (px0 > 10'd15 || py0 > 10'd7) range_bad++;
         if (p_hs0 && !hs0 && hs0_fall < 0) hs0_fall = k;
         if (p_hs3 && !hs3 && hs3_fall < 0) hs3_fall = k;
         if (p_vs0 && !vs0 && vs0_fall < 0) vs0_fall = k;
         if (p_vs3 && !vs3 && vs3_fall < 0) vs3_fall = k;
         p_hs0 = hs0; p_hs3 = hs3; p_vs0 = vs0; p_vs3 = vs3;
      end
      $display("[TB] 3 frames: fe=%0d vs0_low=%0d vs3_low=%0d da=%0d hs_fall %0d/%0d vs_fall %0d/%0d",
               fe_cnt, vs0_low, vs3_low, da_s0, hs0_fall, hs3_fall, vs0_fall, vs3_fall);
      chk("frames_frame_end_count", fe_cnt, 3);
      chk("frames_last_frame_end_k", last_fe, 512);
      chk("frames_period_errors", fe_bad, 0);
      chk("frames_fe_coincidence_errors", coinc_bad, 0);
      chk("frames_vsync_low_d0", vs0_low, 96);
      chk("frames_vsync_low_d3", vs3_low, 96);
      chk("frames_display_clocks", da_s0, 96);
      chk("frames_delay_pixel_diffs", da_diff, 0);
      chk("frames_range_errors", range_bad, 0);
      chk("hsync_fall_d0", hs0_fall, 139);
      chk("hsync_shift_d3_vs_d0", hs3_fall - hs0_fall, 3);
      chk("vsync_fall_d0", vs0_fall, 209);
      chk("vsync_shift_d3_vs_d0", vs3_fall - vs0_fall, 3);

      // Counter at h=11, v=5: inside both sync pulses of the SYNC_DELAY=0 raster.
      run_to(603);
      chk("mid_pre_hsync_d0", hs0, 0);
      chk("mid_pre_vsync_d0", vs0, 0);
      chk("mid_pre_vsync_d3", vs3, 0);
      #2 reset_n = 1'b0;
      #1;
      $display("[TB] async reset mid-frame: hs0=%0b vs0=%0b vs3=%0b", hs0, vs0, vs3);
      chk("mid_async_hsync_d0", hs0, 1);
      chk("mid_async_vsync_d0", vs0, 1);
      chk("mid_async_vsync_d3", vs3, 1);
      chk("mid_async_pixel_x", px0, 0);
      chk("mid_async_pixel_y", py0, 0);
      chk("mid_async_display_area", da0, 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      k = 0;
      tick();
      $display("[TB] restart k=1: x=%0d y=%0d da=%0b hs=%0b vs=%0b", px0, py0, da0, hs0, vs0);
      chk("restart_display_area", da0, 1);
      chk("restart_pixel_x", px0, 0);
      chk("restart_pixel_y", py0, 0);
      chk("restart_hsync_d0", hs0, 1);
      chk("restart_vsync_d0", vs0, 1);
      chk("restart_full_display_area", da_d, 1);
      chk("restart_full_pixel_x", px_d, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
